id_issue_queue: RTL and testbench

Decoded-instruction transmit queue sitting between the decoder and the issue stage. Buffers up to `DEPTH` decoded scoreboard entries and presents them in order over the issue stage's `decoded_instr_valid` / `decoded_instr_ack` handshake. It enforces the rule of at most one unresolved control-flow instruction handed to issue at a time. It also drops every buffered entry on flush.

---
 rtl/id_issue_queue.sv | 70 +++++++
 tb/tb_id_issue_queue.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/id_issue_queue.sv
// id_issue_queue: in-order decoded-instruction queue with single outstanding control-flow gating.
// Define ID_ISSUE_QUEUE_BYPASS_EN to present incoming entries combinationally when the queue is empty.
module id_issue_queue #(
    parameter int DEPTH   = 4,
    parameter int ENTRY_W = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic [ENTRY_W-1:0]         instr_i,
    input  logic                       instr_is_ctrl_flow_i,
    input  logic                       instr_valid_i,
    output logic                       instr_ready_o,
    output logic [ENTRY_W-1:0]         decoded_instr_o,
    output logic                       is_ctrl_flow_o,
    output logic                       decoded_instr_valid_o,
    input  logic                       decoded_instr_ack_i,
    input  logic                       resolve_branch_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [ENTRY_W:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count;
    logic             branch_pending;
    logic [ENTRY_W:0] head;
    logic             empty, byp, deq, rd_en, wr_en;

    assign head          = mem[rd_ptr];
    assign empty         = count == '0;
    assign count_o       = count;
    assign instr_ready_o = count != CW'(DEPTH);

`ifdef ID_ISSUE_QUEUE_BYPASS_EN
    assign byp = empty && instr_valid_i && !flush_i && !(instr_is_ctrl_flow_i && branch_pending);
`else
    assign byp = 1'b0;
`endif

    always_comb begin
        decoded_instr_valid_o = !flush_i && (empty ? byp : !(head[ENTRY_W] && branch_pending));
        decoded_instr_o       = empty ? (byp ? instr_i : '0) : head[ENTRY_W-1:0];
        is_ctrl_flow_o        = empty ? (byp && instr_is_ctrl_flow_i) : head[ENTRY_W];
    end

    assign deq   = decoded_instr_valid_o && decoded_instr_ack_i;
    assign rd_en = deq && !empty;
    // a bypassed entry that is acked in the same cycle never touches storage
    assign wr_en = instr_valid_i && instr_ready_o && !flush_i && !(byp && decoded_instr_ack_i);

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr] <= {instr_is_ctrl_flow_i, instr_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            branch_pending <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count          <= count + CW'(wr_en) - CW'(rd_en);
            branch_pending <= (deq && is_ctrl_flow_o) ? 1'b1 : resolve_branch_i ? 1'b0 : branch_pending;
        end
    end
endmodule

// File: tb/tb_id_issue_queue.sv
// tb_id_issue_queue: directed and random stimulus checked every cycle against a queue-based model.
module tb_id_issue_queue;
    localparam int DEPTH = 4;
    localparam int W     = 64;
`ifdef ID_ISSUE_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic         clk_i = 1'b0;
    logic         rst_i, flush_i, instr_is_ctrl_flow_i, instr_valid_i, instr_ready_o;
    logic [W-1:0] instr_i, decoded_instr_o;
    logic         is_ctrl_flow_o, decoded_instr_valid_o, decoded_instr_ack_i, resolve_branch_i;
    logic [2:0]   count_o;

    id_issue_queue #(.DEPTH(DEPTH), .ENTRY_W(W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .instr_i(instr_i),
        .instr_is_ctrl_flow_i(instr_is_ctrl_flow_i), .instr_valid_i(instr_valid_i),
        .instr_ready_o(instr_ready_o), .decoded_instr_o(decoded_instr_o),
        .is_ctrl_flow_o(is_ctrl_flow_o), .decoded_instr_valid_o(decoded_instr_valid_o),
        .decoded_instr_ack_i(decoded_instr_ack_i), .resolve_branch_i(resolve_branch_i),
        .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    int           checks = 0, passes = 0;
    logic [W:0]   mq[$];
    bit           mbp;
    logic [W-1:0] obs_data;
    logic         obs_valid, obs_ready, obs_cf;
    logic [2:0]   obs_count;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    task automatic cyc(input bit r, f, v, c, input logic [W-1:0] d, input bit a, s);
        bit           ev, ecf, eready, byp_ok, deq, enq;
        logic [W-1:0] ed;
        int           n;
        rst_i = r; flush_i = f; instr_valid_i = v; instr_is_ctrl_flow_i = c;
        instr_i = d; decoded_instr_ack_i = a; resolve_branch_i = s;
        #7;
        n      = mq.size();
        byp_ok = BYP && n == 0 && v && !f && !(c && mbp);
        ev     = !f && (n != 0 ? !(mq[0][W] && mbp) : byp_ok);
        ed     = n != 0 ? mq[0][W-1:0] : d;
        ecf    = n != 0 ? mq[0][W] : c;
        eready = n != DEPTH;
        chk("valid", W'(decoded_instr_valid_o), W'(ev));
        chk("ready", W'(instr_ready_o), W'(eready));
        chk("count", W'(count_o), W'(n));
        if (ev) begin
            chk("data", decoded_instr_o, ed);
            chk("ctrl_flow", W'(is_ctrl_flow_o), W'(ecf));
        end
        obs_data = decoded_instr_o; obs_valid = decoded_instr_valid_o;
        obs_ready = instr_ready_o; obs_cf = is_ctrl_flow_o; obs_count = count_o;
        @(posedge clk_i);
        if (r || f) begin
            mq.delete();
            mbp = 1'b0;
        end else begin
            deq = ev && a;
            enq = v && eready;
            if (deq && ecf) mbp = 1'b1;
            else if (s) mbp = 1'b0;
            if (deq && n != 0) void'(mq.pop_front());
            if (enq && !(deq && n == 0)) mq.push_back({c, d});
        end
        #1;
    endtask

    task automatic idle(input bit a);
        cyc(0, 0, 0, 0, '0, a, 0);
    endtask

    initial begin
        rst_i = 1; flush_i = 0; instr_valid_i = 0; instr_is_ctrl_flow_i = 0;
        instr_i = '0; decoded_instr_ack_i = 0; resolve_branch_i = 0;
        repeat (2) @(posedge clk_i);
        #1;
        mq.delete(); mbp = 0;
        idle(0);
        chk("rst_valid", W'(obs_valid), '0);
        chk("rst_data", obs_data, '0);
        chk("rst_cf", W'(obs_cf), '0);
        chk("rst_count", W'(obs_count), '0);
        chk("rst_ready", W'(obs_ready), W'(1));
        // fill and drain
        for (int i = 1; i <= 4; i++) cyc(0, 0, 1, 0, W'(i * 'h11), 0, 0);
        idle(0);
        chk("full_count", W'(obs_count), W'(4));
        chk("full_ready", W'(obs_ready), '0);
        for (int i = 1; i <= 4; i++) begin
            idle(1);
            chk("drain_data", obs_data, W'(i * 'h11));
        end
        idle(0);
        chk("drained_count", W'(obs_count), '0);
        chk("drained_valid", W'(obs_valid), '0);
        // wrap-around streaming
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 1, 0, W'(100 + i), 1, 0);
            if (i == 5) chk("stream_count", W'(obs_count), BYP ? '0 : W'(1));
        end
        idle(1);
        // branch gating
        cyc(0, 0, 1, 1, W'('hA), 0, 0);
        cyc(0, 0, 1, 1, W'('hB), 0, 0);
        idle(1);
        chk("br_a_data", obs_data, W'('hA));
        idle(1);
        chk("br_b_held", W'(obs_valid), '0);
        cyc(0, 0, 0, 0, '0, 0, 1);
        chk("br_b_held_resolve", W'(obs_valid), '0);
        cyc(0, 0, 0, 0, '0, 1, 1);
        chk("br_b_valid", W'(obs_valid), W'(1));
        chk("br_b_data", obs_data, W'('hB));
        cyc(0, 0, 1, 1, W'('hC), 0, 0);
        idle(0);
        chk("br_pending_kept", W'(obs_valid), '0);
        cyc(0, 0, 0, 0, '0, 0, 1);
        idle(1);
        cyc(0, 0, 0, 0, '0, 0, 1);
        // flush with pending branch
        cyc(0, 0, 1, 1, W'('hD), 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, W'('hE0 + i), 0, 0);
        idle(1);
        cyc(0, 1, 1, 0, W'('hFF), 1, 0);
        chk("flush_valid_same", W'(obs_valid), '0);
        idle(0);
        chk("flush_count", W'(obs_count), '0);
        chk("flush_valid", W'(obs_valid), '0);
        cyc(0, 0, 1, 1, W'('h77), 0, 0);
        idle(0);
        chk("flush_cleared_pending", W'(obs_valid), W'(1));
        idle(1);
        cyc(0, 0, 0, 0, '0, 0, 1);
        // reset mid-operation
        cyc(0, 0, 1, 0, W'('h91), 0, 0);
        cyc(0, 0, 1, 0, W'('h92), 0, 0);
        cyc(1, 0, 1, 0, W'('h93), 1, 0);
        idle(0);
        chk("mid_rst_valid", W'(obs_valid), '0);
        chk("mid_rst_data", obs_data, '0);
        chk("mid_rst_count", W'(obs_count), '0);
        chk("mid_rst_ready", W'(obs_ready), W'(1));
        chk("mid_rst_cf", W'(obs_cf), '0);
`ifdef ID_ISSUE_QUEUE_BYPASS_EN
        cyc(0, 0, 1, 0, W'('h5A), 1, 0);
        chk("byp_valid", W'(obs_valid), W'(1));
        chk("byp_data", obs_data, W'('h5A));
        idle(0);
        chk("byp_count", W'(obs_count), '0);
`endif
        // randomized traffic
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
                $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
                {$urandom, $urandom}, $urandom_range(0, 9) < 6, $urandom_range(0, 4) == 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
